// File: rtl/atm_controller_pkg.sv
// Shared definitions for the ATM transaction controller: FSM state encodings
// and transaction/PIN constants.
package atm_controller_pkg;

    typedef enum logic [2:0] {
        ST_ESPERA_TARJETA = 3'd0,
        ST_ESPERA_PIN     = 3'd1,
        ST_ESPERA_MONTO   = 3'd2,
        ST_FIN            = 3'd3,
        ST_BLOQUEO        = 3'd4
    } atm_state_t;

    localparam int   PIN_DIGITS    = 4;
    localparam logic TIPO_RETIRO   = 1'b1;
    localparam logic TIPO_DEPOSITO = 1'b0;

endpackage

// File: rtl/atm_pulso.sv
// Rising-edge detector: pulses for the first cycle a level is sampled high.
module atm_pulso (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_pulso
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    // Combinational so the FSM acts on the same edge the strobe is first seen.
    assign o_pulso = i_d & ~r_prev;

endmodule

// File: rtl/atm_controller.sv
// ATM transaction controller: card session, serial PIN entry with lockout,
// and a single deposit or withdrawal per session.
module atm_controller
    import atm_controller_pkg::*;
#(
    parameter int MAX_INTENTOS = 3,
    parameter int MONTO_W      = 32,
    parameter int FONDOS_W     = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                TARJETA_RECIBIDA,
    input  logic [15:0]         PIN,
    input  logic [3:0]          DIGITO,
    input  logic                DIGITO_STB,
    input  logic                ERASE_PIN,
    input  logic                ENTER_PIN,
    input  logic                TIPO_TRANS,
    input  logic [MONTO_W-1:0]  MONTO,
    input  logic                MONTO_STB,
    input  logic [FONDOS_W-1:0] FONDOS,
    output logic [FONDOS_W-1:0] BALANCE,
    output logic                BALANCE_ACTUALIZADO,
    output logic                ENTREGAR_DINERO,
    output logic                FONDOS_INSUFICIENTES,
    output logic                PIN_INCORRECTO,
    output logic                ADVERTENCIA,
    output logic                BLOQUEO
);

    localparam int INT_W = $clog2(MAX_INTENTOS + 1);

    atm_state_t          r_state;
    logic [15:0]         r_digitos;
    logic [2:0]          r_cnt;
    logic [INT_W-1:0]    r_intentos;
    logic [FONDOS_W-1:0] r_balance;
    logic                r_act, r_entregar, r_insuf, r_pin_inc, r_adv, r_bloq;

    logic                w_dig_p, w_erase_p, w_enter_p, w_monto_p;
    logic [FONDOS_W-1:0] w_monto_ext;
    logic [FONDOS_W:0]   w_suma;
    logic [INT_W-1:0]    w_int_sig;
    logic                w_pin_lleno;

    atm_pulso u_p_dig   (.clk(clk), .reset(reset), .i_d(DIGITO_STB), .o_pulso(w_dig_p));
    atm_pulso u_p_erase (.clk(clk), .reset(reset), .i_d(ERASE_PIN),  .o_pulso(w_erase_p));
    atm_pulso u_p_enter (.clk(clk), .reset(reset), .i_d(ENTER_PIN),  .o_pulso(w_enter_p));
    atm_pulso u_p_monto (.clk(clk), .reset(reset), .i_d(MONTO_STB),  .o_pulso(w_monto_p));

    assign w_monto_ext = FONDOS_W'(MONTO);
    assign w_suma      = {1'b0, r_balance} + {1'b0, w_monto_ext};
    assign w_int_sig   = r_intentos + 1'b1;
    assign w_pin_lleno = (r_cnt == 3'(PIN_DIGITS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ESPERA_TARJETA;
            r_digitos  <= '0;
            r_cnt      <= '0;
            r_intentos <= '0;
            r_balance  <= '0;
            r_act      <= 1'b0;
            r_entregar <= 1'b0;
            r_insuf    <= 1'b0;
            r_pin_inc  <= 1'b0;
            r_adv      <= 1'b0;
            r_bloq     <= 1'b0;
        end else begin
            r_pin_inc <= 1'b0;
            case (r_state)
                ST_ESPERA_TARJETA: begin
                    if (TARJETA_RECIBIDA) begin
                        r_balance <= FONDOS;
                        r_digitos <= '0;
                        r_cnt     <= '0;
                        r_state   <= ST_ESPERA_PIN;
                    end
                end
                ST_ESPERA_PIN: begin
                    if (!TARJETA_RECIBIDA) begin
                        r_digitos  <= '0;
                        r_cnt      <= '0;
                        r_intentos <= '0;
                        r_adv      <= 1'b0;
                        r_state    <= ST_ESPERA_TARJETA;
                    end else if (w_erase_p) begin
                        r_digitos <= '0;
                        r_cnt     <= '0;
                    end else if (w_enter_p && w_pin_lleno) begin
                        if (r_digitos == PIN) begin
                            r_intentos <= '0;
                            r_adv      <= 1'b0;
                            r_state    <= ST_ESPERA_MONTO;
                        end else begin
                            r_intentos <= w_int_sig;
                            r_pin_inc  <= 1'b1;
                            r_digitos  <= '0;
                            r_cnt      <= '0;
                            if (w_int_sig == INT_W'(MAX_INTENTOS - 1)) r_adv <= 1'b1;
                            if (w_int_sig == INT_W'(MAX_INTENTOS)) begin
                                r_bloq  <= 1'b1;
                                r_state <= ST_BLOQUEO;
                            end
                        end
                    end else if (w_dig_p && !w_enter_p && !w_pin_lleno) begin
                        // A short ENTER is ignored but still outranks a same-cycle digit.
                        r_digitos <= {r_digitos[11:0], DIGITO};
                        r_cnt     <= r_cnt + 3'd1;
                    end
                end
                ST_ESPERA_MONTO: begin
                    if (!TARJETA_RECIBIDA) begin
                        r_digitos  <= '0;
                        r_cnt      <= '0;
                        r_intentos <= '0;
                        r_adv      <= 1'b0;
                        r_state    <= ST_ESPERA_TARJETA;
                    end else if (w_monto_p) begin
                        r_state <= ST_FIN;
                        if (TIPO_TRANS == TIPO_DEPOSITO) begin
                            r_balance <= w_suma[FONDOS_W] ? '1 : w_suma[FONDOS_W-1:0];
                            r_act     <= 1'b1;
                        end else if (w_monto_ext <= r_balance) begin
                            r_balance  <= r_balance - w_monto_ext;
                            r_act      <= 1'b1;
                            r_entregar <= 1'b1;
                        end else begin
                            r_insuf <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    if (!TARJETA_RECIBIDA) begin
                        r_act      <= 1'b0;
                        r_entregar <= 1'b0;
                        r_insuf    <= 1'b0;
                        r_digitos  <= '0;
                        r_cnt      <= '0;
                        r_state    <= ST_ESPERA_TARJETA;
                    end
                end
                ST_BLOQUEO: begin
                    r_bloq <= 1'b1;
                end
                default: r_state <= ST_ESPERA_TARJETA;
            endcase
        end
    end

    assign BALANCE              = r_balance;
    assign BALANCE_ACTUALIZADO  = r_act;
    assign ENTREGAR_DINERO      = r_entregar;
    assign FONDOS_INSUFICIENTES = r_insuf;
    assign PIN_INCORRECTO       = r_pin_inc;
    assign ADVERTENCIA          = r_adv;
    assign BLOQUEO              = r_bloq;

endmodule
